// File: rtl/alu_mdu.sv
// alu_mdu: multi-cycle execute unit. Single-cycle RV32I base ALU operations
// plus iterative (one bit per cycle) M-extension multiply and divide, behind
// a valid/ready handshake so the execute stage can stall.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_flush               abort any in-flight operation
//   i_in_valid/o_in_ready request handshake
//   i_alucode, i_op1/2    operation code and operands
//   o_out_valid/i_out_ready result handshake
//   o_alu_result          registered result
//   o_br_taken            registered branch decision, valid with o_out_valid
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// CALC  | iterative multiply/divide running, one bit per cycle
// DONE  | result presented, waiting for out_ready
module alu_mdu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [5:0]      i_alucode,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_alu_result,
  output logic            o_br_taken
);

  localparam logic [5:0] ALU_LUI  = 6'd0,  ALU_JAL  = 6'd1,  ALU_JALR = 6'd2;
  localparam logic [5:0] ALU_BEQ  = 6'd3,  ALU_BNE  = 6'd4,  ALU_BLT  = 6'd5;
  localparam logic [5:0] ALU_BGE  = 6'd6,  ALU_BLTU = 6'd7,  ALU_BGEU = 6'd8;
  localparam logic [5:0] ALU_LB   = 6'd9,  ALU_LH   = 6'd10, ALU_LW   = 6'd11;
  localparam logic [5:0] ALU_LBU  = 6'd12, ALU_LHU  = 6'd13, ALU_SB   = 6'd14;
  localparam logic [5:0] ALU_SH   = 6'd15, ALU_SW   = 6'd16, ALU_ADD  = 6'd17;
  localparam logic [5:0] ALU_SUB  = 6'd18, ALU_SLT  = 6'd19, ALU_SLTU = 6'd20;
  localparam logic [5:0] ALU_XOR  = 6'd21, ALU_OR   = 6'd22, ALU_AND  = 6'd23;
  localparam logic [5:0] ALU_SLL  = 6'd24, ALU_SRL  = 6'd25, ALU_SRA  = 6'd26;
  localparam logic [5:0] ALU_MUL  = 6'd27, ALU_MULH = 6'd28, ALU_MULHSU = 6'd29;
  localparam logic [5:0] ALU_MULHU = 6'd30, ALU_DIV = 6'd31, ALU_DIVU = 6'd32;
  localparam logic [5:0] ALU_REM  = 6'd33, ALU_REMU = 6'd34;

  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  localparam int CW = SHW + 1;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;    // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   r_mcand;  // multiplicand or divisor magnitude
  logic              r_div, r_hi, r_neg_q, r_neg_r;

  logic [SHW-1:0]    w_shamt;
  logic [XLEN-1:0]   w_base_res, w_spec_res, w_mag1, w_mag2;
  logic              w_base_br, w_is_mul, w_is_div, w_s1, w_s2, w_neg1, w_neg2;
  logic              w_div0, w_ovf, w_spec, w_hi_sel;
  logic [XLEN:0]     w_sum, w_trial;
  logic [2*XLEN-1:0] w_mul_nxt, w_div_nxt, w_acc_nxt, w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_fin;

  assign w_shamt = i_op2[SHW-1:0];

  always_comb begin
    w_base_res = '0;
    w_base_br  = 1'b0;
    case (i_alucode)
      ALU_LUI:            w_base_res = i_op2;
      ALU_JAL, ALU_JALR:  begin w_base_res = i_op2 + XLEN'(4); w_base_br = 1'b1; end
      ALU_BEQ:            w_base_br = (i_op1 == i_op2);
      ALU_BNE:            w_base_br = (i_op1 != i_op2);
      ALU_BLT:            w_base_br = ($signed(i_op1) < $signed(i_op2));
      ALU_BGE:            w_base_br = ($signed(i_op1) >= $signed(i_op2));
      ALU_BLTU:           w_base_br = (i_op1 < i_op2);
      ALU_BGEU:           w_base_br = (i_op1 >= i_op2);
      ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU,
      ALU_SB, ALU_SH, ALU_SW, ALU_ADD:
                          w_base_res = i_op1 + i_op2;
      ALU_SUB:            w_base_res = i_op1 - i_op2;
      ALU_SLT:            w_base_res = {{(XLEN-1){1'b0}}, $signed(i_op1) < $signed(i_op2)};
      ALU_SLTU:           w_base_res = {{(XLEN-1){1'b0}}, i_op1 < i_op2};
      ALU_XOR:            w_base_res = i_op1 ^ i_op2;
      ALU_OR:             w_base_res = i_op1 | i_op2;
      ALU_AND:            w_base_res = i_op1 & i_op2;
      ALU_SLL:            w_base_res = i_op1 << w_shamt;
      ALU_SRL:            w_base_res = i_op1 >> w_shamt;
      ALU_SRA:            w_base_res = $unsigned($signed(i_op1) >>> w_shamt);
      default: ;
    endcase
  end

  // Operand sign handling for the iterative engines
  assign w_is_mul = (i_alucode >= ALU_MUL) && (i_alucode <= ALU_MULHU);
  assign w_is_div = (i_alucode >= ALU_DIV) && (i_alucode <= ALU_REMU);
  assign w_s1     = (i_alucode == ALU_MULH) || (i_alucode == ALU_MULHSU) ||
                    (i_alucode == ALU_DIV)  || (i_alucode == ALU_REM);
  assign w_s2     = (i_alucode == ALU_MULH) || (i_alucode == ALU_DIV) || (i_alucode == ALU_REM);
  assign w_neg1   = w_s1 & i_op1[XLEN-1];
  assign w_neg2   = w_s2 & i_op2[XLEN-1];
  assign w_mag1   = w_neg1 ? -i_op1 : i_op1;
  assign w_mag2   = w_neg2 ? -i_op2 : i_op2;
  assign w_hi_sel = (i_alucode == ALU_MULH) || (i_alucode == ALU_MULHSU) ||
                    (i_alucode == ALU_MULHU) || (i_alucode == ALU_REM) || (i_alucode == ALU_REMU);

  assign w_div0 = (i_op2 == '0);
  assign w_ovf  = ((i_alucode == ALU_DIV) || (i_alucode == ALU_REM)) &&
                  (i_op1 == MIN_INT) && (i_op2 == '1);
  assign w_spec = w_is_div && (w_div0 || w_ovf);

  always_comb begin
    w_spec_res = '0;
    if (w_div0)
      w_spec_res = ((i_alucode == ALU_DIV) || (i_alucode == ALU_DIVU)) ? '1 : i_op1;
    else if (w_ovf)
      w_spec_res = (i_alucode == ALU_DIV) ? i_op1 : '0;
  end

  // One multiply step: add multiplicand to the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_mul_nxt = {w_sum, r_acc[XLEN-1:1]};

  // One restoring divide step: trial-subtract the divisor from the shifted
  // remainder; a borrow (msb of w_trial) means the quotient bit is 0.
  assign w_trial   = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_mcand};
  assign w_div_nxt = w_trial[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                   : {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  assign w_acc_nxt = r_div ? w_div_nxt : w_mul_nxt;

  assign w_prod = r_neg_q ? -w_acc_nxt : w_acc_nxt;
  assign w_quo  = r_neg_q ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
  assign w_rem  = r_neg_r ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];
  assign w_fin  = r_div ? (r_hi ? w_rem : w_quo)
                        : (r_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0]);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_mcand      <= '0;
      r_div        <= 1'b0;
      r_hi         <= 1'b0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      o_alu_result <= '0;
      o_br_taken   <= 1'b0;
    end else if (i_flush) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_in_valid) begin
          if (w_spec) begin
            o_alu_result <= w_spec_res;
            o_br_taken   <= 1'b0;
            r_state      <= DONE;
          end else if (w_is_mul || w_is_div) begin
            r_acc      <= {{XLEN{1'b0}}, w_mag1};
            r_mcand    <= w_mag2;
            r_cnt      <= CW'(XLEN);
            r_div      <= w_is_div;
            r_hi       <= w_hi_sel;
            r_neg_q    <= w_neg1 ^ w_neg2;
            r_neg_r    <= w_neg1;
            o_br_taken <= 1'b0;
            r_state    <= CALC;
          end else begin
            o_alu_result <= w_base_res;
            o_br_taken   <= w_base_br;
            r_state      <= DONE;
          end
        end
        CALC: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            o_alu_result <= w_fin;
            r_state      <= DONE;
          end
        end
        DONE: if (i_out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_in_ready  = (r_state == IDLE) && !i_flush;
  assign o_out_valid = (r_state == DONE);

endmodule

// File: tb/tb_alu_mdu.sv
module tb_alu_mdu;

  localparam logic [5:0] C_LUI = 0, C_BLT = 5, C_ADD = 17, C_SUB = 18;
  localparam logic [5:0] C_MUL = 27, C_MULH = 28, C_MULHSU = 29, C_MULHU = 30;
  localparam logic [5:0] C_DIV = 31, C_DIVU = 32, C_REM = 33, C_REMU = 34;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready, br_taken;
  logic [5:0]  alucode;
  logic [31:0] op1, op2, alu_result;

  alu_mdu dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .i_alucode(alucode), .i_op1(op1), .i_op2(op2),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_alu_result(alu_result), .o_br_taken(br_taken)
  );

  typedef struct {
    logic [31:0] res;
    logic        br;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0;
  int   cyc = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: held low

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      2: out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain 64-bit arithmetic from the RISC-V rules.
  task automatic model(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic br, output int lat);
    longint p;
    longint unsigned pu;
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    r = 0; br = 0; lat = 1;
    case (c)
      0: r = b;
      1, 2: begin r = b + 4; br = 1; end
      3: br = (a == b);
      4: br = (a != b);
      5: br = (sa < sb);
      6: br = (sa >= sb);
      7: br = (a < b);
      8: br = (a >= b);
      9, 10, 11, 12, 13, 14, 15, 16, 17: r = a + b;
      18: r = a - b;
      19: r = (sa < sb) ? 1 : 0;
      20: r = (a < b) ? 1 : 0;
      21: r = a ^ b;
      22: r = a | b;
      23: r = a & b;
      24: r = a << b[4:0];
      25: r = a >> b[4:0];
      26: r = sa >>> b[4:0];
      27: begin pu = {32'b0, a} * {32'b0, b}; r = pu[31:0]; lat = 33; end
      28: begin p = longint'(sa) * longint'(sb); r = p[63:32]; lat = 33; end
      29: begin p = longint'(sa) * longint'({32'b0, b}); r = p[63:32]; lat = 33; end
      30: begin pu = {32'b0, a} * {32'b0, b}; r = pu[63:32]; lat = 33; end
      31: begin
        if (b == 0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
        else begin r = sa / sb; lat = 33; end
      end
      32: begin
        if (b == 0) r = 32'hFFFFFFFF;
        else begin r = a / b; lat = 33; end
      end
      33: begin
        if (b == 0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 0;
        else begin r = sa % sb; lat = 33; end
      end
      34: begin
        if (b == 0) r = a;
        else begin r = a % b; lat = 33; end
      end
      default: ;
    endcase
  endtask

  task automatic issue(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                       input bit track);
    exp_t e;
    int n;
    logic rd;
    model(c, a, b, e.res, e.br, e.lat);
    alucode = c; op1 = a; op2 = b; in_valid = 1'b1;
    n = 0;
    rd = 1'b0;
    while (!rd && n < 300) begin
      @(negedge clk);
      rd = in_ready;
      n++;
    end
    if (!rd) begin
      check("accept_timeout", 32'(rd), 32'd1);
      in_valid = 1'b0;
      return;
    end
    e.acc = cyc;
    if (track) q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(0, 16);
      4: return -$urandom_range(1, 16);
      default: return $urandom;
    endcase
  endfunction

  // Monitor / scoreboard
  initial begin
    bit   prev_v, chk_idle;
    int   first;
    exp_t e;
    prev_v = 0; chk_idle = 0; first = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 0; chk_idle = 0;
      end else begin
        if (chk_idle && !flush) begin
          check("idle_after_take.in_ready", 32'(in_ready), 32'd1);
          check("idle_after_take.out_valid", 32'(out_valid), 32'd0);
        end
        chk_idle = 0;
        if (out_valid && !prev_v) first = cyc;
        if (out_valid) begin
          check("in_ready_in_done", 32'(in_ready), 32'd0);
          if (q.size() == 0) begin
            check("unexpected_out_valid", 32'(out_valid), 32'd0);
          end else if (out_ready) begin
            e = q.pop_front();
            check("result", alu_result, e.res);
            check("br_taken", 32'(br_taken), 32'(e.br));
            check("latency", 32'(first - e.acc), 32'(e.lat));
            chk_idle = 1;
          end else begin
            check("hold.result", alu_result, q[0].res);
            check("hold.br_taken", 32'(br_taken), 32'(q[0].br));
          end
        end
        prev_v = out_valid;
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; alucode = 0; op1 = 0; op2 = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.alu_result", alu_result, 32'd0);
    check("reset.br_taken", 32'(br_taken), 32'd0);
    @(posedge clk);
    #1;

    // Directed cases
    issue(C_ADD, 32'd7, 32'hFFFFFFFF, 1);
    issue(C_BLT, 32'hFFFFFFFF, 32'd1, 1);
    issue(C_LUI, 32'd5, 32'hABCDE000, 1);
    issue(C_MUL, 32'hFFFFFFFF, 32'd2, 1);
    issue(C_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    issue(C_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    issue(C_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    issue(C_DIV, -32'd7, 32'd2, 1);
    issue(C_REM, -32'd7, 32'd2, 1);
    issue(C_DIVU, 32'd100, 32'd7, 1);
    issue(C_REMU, 32'd100, 32'd7, 1);
    issue(C_DIV, 32'd12345, 32'd0, 1);
    issue(C_REMU, 32'd5, 32'd0, 1);
    issue(C_DIV, 32'h80000000, 32'hFFFFFFFF, 1);
    issue(C_REM, 32'h80000000, 32'hFFFFFFFF, 1);
    drain();

    // Back-pressure: hold DONE with out_ready low
    rdy_mode = 2;
    @(posedge clk);
    #1;
    issue(C_SUB, 32'd10, 32'd3, 1);
    repeat (12) @(posedge clk);
    #1 rdy_mode = 0;
    drain();

    // in_valid presented throughout CALC must be ignored
    issue(C_DIVU, 32'd1000, 32'd7, 1);
    alucode = C_ADD; op1 = 32'd1; op2 = 32'd1; in_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("in_ready_in_calc", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    // Flush at CALC cycle 5 of a DIVU
    issue(C_DIVU, 32'd99999, 32'd13, 0);
    repeat (4) @(posedge clk);
    #1 flush = 1;
    @(negedge clk);
    check("flush.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 flush = 0;
    @(negedge clk);
    check("post_flush.in_ready", 32'(in_ready), 32'd1);
    check("post_flush.out_valid", 32'(out_valid), 32'd0);
    repeat (40) @(posedge clk);
    #1;

    // Reset at CALC cycle 20 of a DIV
    issue(C_DIV, -32'd5000, 32'd7, 0);
    repeat (19) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("post_rst.in_ready", 32'(in_ready), 32'd1);
    check("post_rst.out_valid", 32'(out_valid), 32'd0);
    check("post_rst.alu_result", alu_result, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    issue(C_SUB, 32'd3, 32'd5, 1);
    drain();

    // Randomized traffic with random back-pressure
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      logic [5:0] c;
      c = ($urandom_range(0, 40) > 34) ? 6'd45 : 6'($urandom_range(0, 34));
      issue(c, rnd_op(), rnd_op(), 1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    rdy_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, multi-cycle successor to the single-cycle execute ALU. It keeps every base RV32I `alucode` operation, including branch compare, and adds the RISC-V M-extension operations: multiply, multiply-high, divide and remainder. Multiply and divide run as iterative one-bit-per-cycle engines behind a valid/ready handshake, so the execute stage can stall on them. The block sits in the execute stage between the operand muxes and the writeback/branch logic.

## Interface
- `XLEN`, default 32: operand and result width; must be a power of two ≥ 8.
- `SHW`, default `$clog2(XLEN)`: shift-amount width; derived, do not override.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `flush` in 1: aborts any in-flight operation.
- `in_valid` in 1: request valid.
- `in_ready` out 1: block can accept a request.
- `alucode` in 6: operation. Uses the shared `ALU_*` codes plus new `ALU_MUL`, `ALU_MULH`, `ALU_MULHSU`, `ALU_MULHU`, `ALU_DIV`, `ALU_DIVU`, `ALU_REM`, `ALU_REMU`.
- `op1` in XLEN: operand 1.
- `op2` in XLEN: operand 2.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer takes the result.
- `alu_result` out XLEN: result, registered.
- `br_taken` out 1: branch decision, registered, valid with `out_valid`.

## Operation
- **States:** IDLE, CALC, DONE.
- **IDLE:**
  - `in_ready`=1.
  - A request is accepted when `in_valid`=1.
  - Base ops: compute the same semantics as the base ALU, register the result, go to DONE.
  - Mul/div ops: latch the operands and the sign information, load counter=XLEN, go to CALC.
- **Base-op semantics:**
  - Shifts use `op2[SHW-1:0]`. SRA is arithmetic.
  - LUI: result is `op2`.
  - JAL/JALR: result is `op2`+4 and `br_taken`=1.
  - Loads and stores: result is `op1`+`op2`.
  - Branch ops: result is 0 and `br_taken` is the comparison.
  - Unknown code: result 0, `br_taken`=0.
- **Division special cases** (checked at accept; skip CALC and go straight to DONE):
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give `op1`.
  - Signed overflow (`op1`=-2^(XLEN-1) and `op2`=-1): DIV gives `op1`; REM gives 0.
- **CALC, multiply:**
  - Operate on magnitudes. The multiplicand is sign-extended to magnitude only for signed operands: MULH both signed, MULHSU `op1` signed only.
  - Unsigned shift-add into a 2·XLEN accumulator, one bit per cycle.
  - At counter 0, negate if the operand signs differ.
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
- **CALC, divide:**
  - Restoring shift-subtract on magnitudes, one quotient bit per cycle.
  - Signed fixup: the quotient is negated if the signs differ; the remainder takes the dividend's sign.
  - `in_ready`=0 throughout CALC.
- **DONE:**
  - `out_valid`=1; `alu_result` and `br_taken` are held stable.
  - Leave to IDLE when `out_ready`=1.
  - A new request cannot be accepted in the same cycle (`in_ready`=0 in DONE).
- **`flush`:**
  - Highest priority after `rst`. In any state, the next state is IDLE.
  - The current result is discarded; no `out_valid` is produced for it.
  - A request presented in the flush cycle is not accepted (`in_ready` is forced to 0 while `flush`=1).
- **`br_taken`:** 0 for all mul/div ops.

## Timing
- **Reset** (next rising edge with `rst`=1): state IDLE, `in_ready`=1, `out_valid`=0, `alu_result`=0, `br_taken`=0, counter=0.
- **Base op latency:** accept in cycle N, `out_valid`=1 in cycle N+1.
- **Div special case latency:** N+1.
- **Mul/div latency:** accept in N, CALC for cycles N+1..N+XLEN, `out_valid`=1 in cycle N+XLEN+1.
- **Throughput:** with `out_ready` held at 1, one base op every 2 cycles (accept, then DONE).
- **Back-pressure:** `out_ready`=0 holds DONE indefinitely with the result unchanged.
- **Reset or flush mid-CALC:** abandons the operation; the next cycle is IDLE with `in_ready`=1.
- **Simultaneous `flush` and `out_ready` in DONE:** go to IDLE; the result counts as dropped, so the consumer must ignore it.

## Test plan
- **Reset then base op:** reset, then ADD `op1`=7, `op2`=0xFFFFFFFF → `out_valid` one cycle later with 6, `br_taken`=0. Also BLT `op1`=-1, `op2`=1 → `br_taken`=1, result 0.
- **Multiply family:** MUL 0xFFFFFFFF×2 → 0xFFFFFFFE. MULH -1×-1 → 0. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU -1×0xFFFFFFFF → 0xFFFFFFFF. Each arrives exactly 33 cycles after accept.
- **Divide signs:** DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- **Divide special cases:** DIV x/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/-1 → 0x80000000; REM 0x80000000/-1 → 0. All arrive 1 cycle after accept.
- **Back-pressure and handshake:** hold `out_ready`=0 for 10 cycles in DONE → result stable, `in_ready`=0. Release → IDLE next cycle. Concurrently check `in_valid` is ignored while in CALC.
- **Abort:** assert `flush` at CALC cycle 5 of a DIVU, and separately `rst` at CALC cycle 20 → no `out_valid`, IDLE next cycle. A following SUB 3−5 returns 0xFFFFFFFE.
